// File: rtl/hilo_mult_unit.sv
// hilo_mult_unit
// Iterative 32x32 radix-2 shift-add multiplier producing the 64-bit HI/LO
// result for mult/multu/madd/maddu, then issuing exactly one write strobe to
// the register file HI/LO port (the register file overwrites or accumulates).
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   start            request, accepted only while busy=0
//   op[1:0]          0=mult 1=multu 2=madd 3=maddu
//   a[31:0], b[31:0] operands, latched on accept
//   busy             high from accept edge until the write cycle completes
//   done             one-cycle pulse together with the write strobe
//   rf_write_enable  register file write enable
//   rf_mul[1:0]      1=overwrite {hi,lo}, 2=accumulate {hi,lo}, 0 when idle
//   rf_write_data_1  product[31:0]  (lo)
//   rf_write_data_2  product[63:32] (hi)
module hilo_mult_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        rf_write_enable,
  output logic [1:0]  rf_mul,
  output logic [31:0] rf_write_data_1,
  output logic [31:0] rf_write_data_2
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Magnitude as 33-bit unsigned; |0x80000000| = 0x80000000 fits without overflow.
  function automatic logic [32:0] mag33(input logic [31:0] v, input logic is_signed);
    logic [32:0] ext;
    ext = {is_signed & v[31], v};
    if (ext[32]) begin
      mag33 = 33'd0 - ext;
    end else begin
      mag33 = ext;
    end
  endfunction

  state_t      state_r;
  state_t      state_next_s;
  logic [63:0] mcand_r;   // multiplicand magnitude, shifted left each iteration
  logic [32:0] mplier_r;  // multiplier magnitude, shifted right each iteration
  logic [63:0] acc_r;
  logic [4:0]  cnt_r;
  logic        neg_r;
  logic [1:0]  mode_r;    // register file mode for the op in flight

  logic        op_signed_s;
  logic [32:0] abs_a_s;
  logic [32:0] abs_b_s;
  logic        neg_s;
  logic [63:0] acc_fix_s;

  logic        busy_s, done_s, we_s;
  logic [1:0]  mul_s;
  logic [63:0] data_s;
  logic        busy_r, done_r, we_r;
  logic [1:0]  mul_r;
  logic [63:0] data_r;

  // Operand conditioning for the accept cycle.
  always_comb begin
    op_signed_s = ~op[0];
    abs_a_s     = mag33(a, op_signed_s);
    abs_b_s     = mag33(b, op_signed_s);
    neg_s       = op_signed_s & (a[31] ^ b[31]);
  end

  // Final sign correction of the unsigned magnitude product.
  always_comb begin
    if (neg_r) begin
      acc_fix_s = 64'd0 - acc_r;
    end else begin
      acc_fix_s = acc_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; RUN lasts exactly 32 cycles regardless of operand values.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == 5'd31) begin
          state_next_s = ST_FIX;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_FIX:  state_next_s = ST_WB;
      ST_WB:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath: operand latch, shift-add iterations, sign fix.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= 64'd0;
      mplier_r <= 33'd0;
      acc_r    <= 64'd0;
      cnt_r    <= 5'd0;
      neg_r    <= 1'b0;
      mode_r   <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mcand_r  <= {31'd0, abs_a_s};
            mplier_r <= abs_b_s;
            acc_r    <= 64'd0;
            cnt_r    <= 5'd0;
            neg_r    <= neg_s;
            mode_r   <= op[1] ? 2'd2 : 2'd1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_RUN: begin
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= {mcand_r[62:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[32:1]};
          cnt_r    <= cnt_r + 5'd1;
        end
        ST_FIX:  acc_r <= acc_fix_s;
        ST_WB:   acc_r <= acc_r;
        default: acc_r <= acc_r;
      endcase
    end
  end

  // Output decode: values computed one cycle early so the outputs can be registered.
  always_comb begin
    busy_s = (state_next_s != ST_IDLE);
    if (state_r == ST_FIX) begin
      we_s   = 1'b1;
      done_s = 1'b1;
      mul_s  = mode_r;
      data_s = acc_fix_s;
    end else begin
      we_s   = 1'b0;
      done_s = 1'b0;
      mul_s  = 2'd0;
      data_s = 64'd0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      we_r   <= 1'b0;
      mul_r  <= 2'd0;
      data_r <= 64'd0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
      we_r   <= we_s;
      mul_r  <= mul_s;
      data_r <= data_s;
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign rf_write_enable = we_r;
  assign rf_mul          = mul_r;
  assign rf_write_data_1 = data_r[31:0];
  assign rf_write_data_2 = data_r[63:32];

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Scoreboard bench for hilo_mult_unit: a posedge reference model decides which
// requests are accepted and pushes the expected strobe; a negedge monitor pops
// and compares whenever the DUT presents a write strobe.
module tb_hilo_mult_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, rf_write_enable;
  logic [1:0]  rf_mul;
  logic [31:0] rf_write_data_1, rf_write_data_2;

  hilo_mult_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .rf_write_enable(rf_write_enable), .rf_mul(rf_mul),
    .rf_write_data_1(rf_write_data_1), .rf_write_data_2(rf_write_data_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  exp_t        mdl_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          m_left = 0;
  int          strobe_cnt = 0;
  logic [63:0] rf_model = 64'd0;

  // Reference product: exact signed or unsigned 64-bit value.
  function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    if (o == 2'd0 || o == 2'd2) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: acceptance and expected result, evaluated at each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_left = 0;
      exp_q.delete();
    end else if (m_left != 0) begin
      m_left--;
    end else if (start) begin
      mdl_e.mode = (op == 2'd2 || op == 2'd3) ? 2'd2 : 2'd1;
      mdl_e.data = ref_prod(op, a, b);
      mdl_e.due  = cyc + 33;
      exp_q.push_back(mdl_e);
      m_left = 34;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on every falling edge.
  initial forever begin
    @(negedge clk);
    if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
      total++;
      bad++;
      $display("FAIL strobe_missing: no strobe by cycle %0d, want one at %0d", cyc, exp_q[0].due);
      void'(exp_q.pop_front());
    end
    chk("busy", 64'(busy), 64'(m_left != 0));
    if (rf_write_enable) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL strobe_unexpected: got strobe data %h want none (cycle %0d)",
                 {rf_write_data_2, rf_write_data_1}, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_cycle", 64'(cyc), 64'(mon_e.due));
        chk("rf_mul", 64'(rf_mul), 64'(mon_e.mode));
        chk("data", {rf_write_data_2, rf_write_data_1}, mon_e.data);
        chk("done_with_we", 64'(done), 64'd1);
      end
      if (rf_mul == 2'd2) begin
        rf_model = rf_model + {rf_write_data_2, rf_write_data_1};
      end else begin
        rf_model = {rf_write_data_2, rf_write_data_1};
      end
    end else begin
      chk("idle_ctl", {61'd0, done, rf_mul}, 64'd0);
      chk("idle_data", {rf_write_data_2, rf_write_data_1}, 64'd0);
    end
  end

  // Issue one op starting at a falling edge; returns at the falling edge after its capture edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom_range(3, 0)); a = $urandom; b = $urandom;
    repeat (34) @(negedge clk);
  endtask

  int s0;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {57'd0, busy, done, rf_write_enable, rf_mul, 2'b00},
        64'd0);
    chk("reset_data", {rf_write_data_2, rf_write_data_1}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed products and signed corners.
    issue(2'd0, 32'hFFFFFFFD, 32'd7);
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(2'd0, 32'h80000000, 32'h80000000);
    issue(2'd0, 32'hFFFFFFFF, 32'h80000000);
    issue(2'd0, 32'd0, 32'h12345678);
    issue(2'd1, 32'h80000000, 32'hFFFFFFFF);

    // Overwrite then accumulate sequence into the register file model.
    issue(2'd0, 32'd5, 32'd7);
    issue(2'd3, 32'h00010000, 32'h00010000);
    issue(2'd2, 32'hFFFFFFFE, 32'd3);
    chk("rf_accum", rf_model, 64'd35 + 64'h00000000_FFFFFFFA);

    // Start pulses during RUN (E5) and during WB must be ignored.
    s0 = strobe_cnt;
    start = 1'b1; op = 2'd0; a = 32'h00001234; b = 32'hFFFF5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'hDEADBEEF; b = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    repeat (28) @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'h11111111; b = 32'h22222222;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignore_strobes", 64'(strobe_cnt - s0), 64'd1);

    // Reset at E10 aborts the op with no write.
    s0 = strobe_cnt;
    start = 1'b1; op = 2'd0; a = 32'h0000_0101; b = 32'h0000_0202;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_outs", {59'd0, busy, done, rf_write_enable, rf_mul}, 64'd0);
    repeat (40) @(negedge clk);
    chk("rst_no_strobe", 64'(strobe_cnt - s0), 64'd0);
    issue(2'd2, 32'h7FFFFFFF, 32'h80000001);

    // start held high for three back-to-back ops.
    s0 = strobe_cnt;
    start = 1'b1; op = 2'd0; a = $urandom; b = $urandom;
    @(negedge clk);
    op = 2'd1; a = $urandom; b = $urandom;
    repeat (35) @(negedge clk);
    op = 2'd2; a = $urandom; b = $urandom;
    repeat (35) @(negedge clk);
    start = 1'b0;
    repeat (36) @(negedge clk);
    chk("held_strobes", 64'(strobe_cnt - s0), 64'd3);

    // Random ops.
    for (int i = 0; i < 12; i++) begin
      issue(2'($urandom_range(3, 0)), $urandom, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
